// File: rtl/rom_download_ctrl.sv
// Splits 16-bit ioctl download words into byte writes for four on-chip ROM regions and
// holds the core in reset while a download runs, plus a settle time afterwards.
module rom_download_ctrl #(
    parameter logic [7:0]  INDEX    = 8'd0,
    parameter logic [26:0] R0_END   = 27'h08000,
    parameter logic [26:0] R1_END   = 27'h0C000,
    parameter logic [26:0] R2_END   = 27'h10000,
    parameter logic [26:0] R3_END   = 27'h18000,
    parameter int unsigned RST_HOLD = 16
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [26:0] ioctl_addr,
    input  logic [15:0] ioctl_dout,
    output logic        ioctl_wait,
    output logic [3:0]  rom_wr,
    output logic [15:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic        core_reset,
    output logic        dl_done,
    output logic        err_flag
);

    localparam int unsigned CntW = $clog2(RST_HOLD + 1);

    // One extra bit so addr+1 of the top word cannot wrap back into region 0.
    localparam logic [27:0] End0 = {1'b0, R0_END};
    localparam logic [27:0] End1 = {1'b0, R1_END};
    localparam logic [27:0] End2 = {1'b0, R2_END};
    localparam logic [27:0] End3 = {1'b0, R3_END};

    typedef enum logic [1:0] {
        StIdle,
        StLo,
        StHi
    } state_e;

    state_e          state_q, state_d;
    logic [26:0]     addr_q, addr_d;
    logic [7:0]      hi_byte_q, hi_byte_d;
    logic            wait_q, wait_d;
    logic [3:0]      wr_q, wr_d;
    logic [15:0]     raddr_q, raddr_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            core_rst_q, core_rst_d;
    logic            dl_seen_q, dl_seen_d;
    logic            done_q, done_d;

    logic            active;
    logic [27:0]     abs_byte;
    logic [3:0]      sel_oh;
    logic [15:0]     offset;
    logic            oob;

    assign active = ioctl_download && (ioctl_index == INDEX);

    // The decoder serves the byte about to be registered: the incoming low byte while
    // idle, the latched word's high byte while in LO.
    assign abs_byte = (state_q == StLo) ? ({1'b0, addr_q} + 28'd1) : {1'b0, ioctl_addr};

    always_comb begin
        sel_oh = '0;
        oob    = 1'b0;
        offset = 16'(abs_byte - End2);
        if (abs_byte < End0) begin
            sel_oh = 4'b0001;
            offset = abs_byte[15:0];
        end else if (abs_byte < End1) begin
            sel_oh = 4'b0010;
            offset = 16'(abs_byte - End0);
        end else if (abs_byte < End2) begin
            sel_oh = 4'b0100;
            offset = 16'(abs_byte - End1);
        end else if (abs_byte < End3) begin
            sel_oh = 4'b1000;
        end else begin
            oob = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        hi_byte_d = hi_byte_q;
        wait_d    = wait_q;
        wr_d      = '0;
        raddr_d   = raddr_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        unique case (state_q)
            StIdle: begin
                if (ioctl_wr && active) begin
                    state_d   = StLo;
                    addr_d    = ioctl_addr;
                    hi_byte_d = ioctl_dout[15:8];
                    rdata_d   = ioctl_dout[7:0];
                    raddr_d   = offset;
                    wr_d      = sel_oh;
                    wait_d    = 1'b1;
                    if (oob) begin
                        err_d = 1'b1;
                    end
                end
            end
            StLo: begin
                state_d = StHi;
                rdata_d = hi_byte_q;
                raddr_d = offset;
                wr_d    = sel_oh;
                if (oob || ioctl_wr) begin
                    err_d = 1'b1;
                end
            end
            StHi: begin
                state_d = StIdle;
                wait_d  = 1'b0;
                if (ioctl_wr) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                wait_d  = 1'b0;
            end
        endcase
    end

    // Core reset follows any download index; dl_done only after a real download.
    always_comb begin
        cnt_d      = cnt_q;
        core_rst_d = core_rst_q;
        dl_seen_d  = dl_seen_q;
        done_d     = 1'b0;
        if (ioctl_download) begin
            cnt_d      = CntW'(RST_HOLD);
            core_rst_d = 1'b1;
            dl_seen_d  = 1'b1;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
                core_rst_d = 1'b0;
                done_d     = dl_seen_q;
                dl_seen_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            hi_byte_q  <= '0;
            wait_q     <= 1'b0;
            wr_q       <= '0;
            raddr_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            cnt_q      <= CntW'(RST_HOLD);
            core_rst_q <= 1'b1;
            dl_seen_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            hi_byte_q  <= hi_byte_d;
            wait_q     <= wait_d;
            wr_q       <= wr_d;
            raddr_q    <= raddr_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            core_rst_q <= core_rst_d;
            dl_seen_q  <= dl_seen_d;
            done_q     <= done_d;
        end
    end

    assign ioctl_wait = wait_q;
    assign rom_wr     = wr_q;
    assign rom_addr   = raddr_q;
    assign rom_data   = rdata_q;
    assign core_reset = core_rst_q;
    assign dl_done    = done_q;
    assign err_flag   = err_q;

endmodule

// File: tb/tb_rom_download_ctrl.sv
// Randomized self-checking bench for rom_download_ctrl against a region-table byte model.
module tb_rom_download_ctrl;

    localparam int unsigned RstHold = 16;
    localparam int unsigned RegEnd [4] = '{32'h8000, 32'hC000, 32'h10000, 32'h18000};

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [26:0] ioctl_addr;
    logic [15:0] ioctl_dout;
    logic        ioctl_wait;
    logic [3:0]  rom_wr;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic        core_reset;
    logic        dl_done;
    logic        err_flag;

    int   checks = 0;
    int   errors = 0;
    logic err_exp = 1'b0;

    always #5 clk_sys = ~clk_sys;

    rom_download_ctrl dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .rom_wr         (rom_wr),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .core_reset     (core_reset),
        .dl_done        (dl_done),
        .err_flag       (err_flag)
    );

    // Which region (if any) owns an absolute byte address, and the offset inside it.
    function automatic void model_byte(input int unsigned a, output logic [3:0] wr,
                                       output logic [15:0] off);
        int unsigned start;
        start = 0;
        wr    = '0;
        off   = '0;
        for (int i = 0; i < 4; i++) begin
            if (a >= start && a < RegEnd[i]) begin
                wr  = 4'(1 << i);
                off = 16'(a - start);
            end
            start = RegEnd[i];
        end
    endfunction

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    // Issue one word and check both byte cycles plus the return to idle.
    task automatic word(input logic [26:0] addr, input logic [15:0] dout);
        logic [3:0]  ewr;
        logic [15:0] eoff;
        logic        hi_in_range;
        logic [15:0] hi_off;
        ioctl_wr   = 1'b1;
        ioctl_addr = addr;
        ioctl_dout = dout;
        step();
        ioctl_wr = 1'b0;
        model_byte(int'(addr), ewr, eoff);
        if (ewr == 4'b0) err_exp = 1'b1;
        checks++;
        if ({ioctl_wait, rom_wr} !== {1'b1, ewr})
            $display("FAIL lo_strobe addr=%h: got wait=%b wr=%b exp wait=1 wr=%b",
                     addr, ioctl_wait, rom_wr, ewr);
        if ({ioctl_wait, rom_wr} !== {1'b1, ewr}) errors++;
        if (ewr != 4'b0) begin
            checks++;
            if ({rom_addr, rom_data} !== {eoff, dout[7:0]}) begin
                errors++;
                $display("FAIL lo_byte addr=%h: got %h/%h exp %h/%h",
                         addr, rom_addr, rom_data, eoff, dout[7:0]);
            end
        end
        checks++;
        if (err_flag !== err_exp) begin
            errors++;
            $display("FAIL lo_err addr=%h: got %b exp %b", addr, err_flag, err_exp);
        end
        step();
        model_byte(int'(addr) + 1, ewr, eoff);
        hi_in_range = (ewr != 4'b0);
        hi_off      = eoff;
        if (!hi_in_range) err_exp = 1'b1;
        checks++;
        if ({ioctl_wait, rom_wr, rom_data} !== {1'b1, ewr, dout[15:8]}) begin
            errors++;
            $display("FAIL hi_byte addr=%h: got wait=%b wr=%b data=%h exp 1 %b %h",
                     addr, ioctl_wait, rom_wr, rom_data, ewr, dout[15:8]);
        end
        if (hi_in_range) begin
            checks++;
            if (rom_addr !== eoff) begin
                errors++;
                $display("FAIL hi_addr addr=%h: got %h exp %h", addr, rom_addr, eoff);
            end
        end
        checks++;
        if (err_flag !== err_exp) begin
            errors++;
            $display("FAIL hi_err addr=%h: got %b exp %b", addr, err_flag, err_exp);
        end
        step();
        checks++;
        if ({ioctl_wait, rom_wr, rom_data} !== {1'b0, 4'b0, dout[15:8]}) begin
            errors++;
            $display("FAIL idle_after addr=%h: got wait=%b wr=%b data=%h exp 0 0000 %h",
                     addr, ioctl_wait, rom_wr, rom_data, dout[15:8]);
        end
        if (hi_in_range) begin
            checks++;
            if (rom_addr !== hi_off) begin
                errors++;
                $display("FAIL idle_hold addr=%h: got %h exp %h", addr, rom_addr, hi_off);
            end
        end
    endtask

    // Counts core_reset-high cycles from the current one; expects a dl_done pulse at release.
    task automatic count_hold(input string name, input logic expect_done);
        int n;
        n = 0;
        while (core_reset === 1'b1 && n < 64) begin
            checks++;
            if (dl_done !== 1'b0) begin
                errors++;
                $display("FAIL %s_early_done: got %b exp 0", name, dl_done);
            end
            n++;
            step();
        end
        checks++;
        if (n != RstHold) begin
            errors++;
            $display("FAIL %s_hold_len: got %0d exp %0d", name, n, RstHold);
        end
        checks++;
        if (dl_done !== expect_done) begin
            errors++;
            $display("FAIL %s_done: got %b exp %b", name, dl_done, expect_done);
        end
        step();
        checks++;
        if (dl_done !== 1'b0 || core_reset !== 1'b0) begin
            errors++;
            $display("FAIL %s_after: got done=%b core_reset=%b exp 0 0", name, dl_done,
                     core_reset);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if ({ioctl_wait, rom_wr, rom_addr, rom_data, core_reset, dl_done, err_flag} !==
            {1'b0, 4'b0, 16'h0, 8'h0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got wait=%b wr=%b addr=%h data=%h cr=%b done=%b err=%b",
                     ioctl_wait, rom_wr, rom_addr, rom_data, core_reset, dl_done, err_flag);
        end
        reset = 1'b0;
        count_hold("reset_release", 1'b0);
        repeat (4) begin
            step();
            checks++;
            if ({ioctl_wait, dl_done, core_reset} !== 3'b000) begin
                errors++;
                $display("FAIL reset_idle: got wait=%b done=%b cr=%b exp 000",
                         ioctl_wait, dl_done, core_reset);
            end
        end
    endtask

    task automatic test_basic();
        ioctl_download = 1'b1;
        ioctl_index    = 8'd0;
        step();
        checks++;
        if (core_reset !== 1'b1) begin
            errors++;
            $display("FAIL basic_core_reset: got %b exp 1", core_reset);
        end
        word(27'h0000000, 16'hBEEF);
    endtask

    task automatic test_regions();
        word(27'h000C000, 16'h1234);
        word(27'h0007FFE, 16'hCAFE);
        word(27'h000BFFE, 16'h5566);
        word(27'h0008000, 16'h0102);
        word(27'h0010000, 16'hA0B0);
        word(27'h0017FFE, 16'hFACE);
    endtask

    task automatic test_oob();
        checks++;
        if (err_flag !== 1'b0) begin
            errors++;
            $display("FAIL oob_pre_err: got %b exp 0", err_flag);
        end
        ioctl_wr   = 1'b1;
        ioctl_addr = 27'h0018000;
        ioctl_dout = 16'hA5A5;
        step();
        err_exp = 1'b1;
        // A second strobe while busy, aimed at a valid address so acceptance would show.
        ioctl_addr = 27'h0000010;
        ioctl_dout = 16'h7777;
        checks++;
        if ({ioctl_wait, rom_wr, err_flag} !== {1'b1, 4'b0, 1'b1}) begin
            errors++;
            $display("FAIL oob_lo: got wait=%b wr=%b err=%b exp 1 0000 1",
                     ioctl_wait, rom_wr, err_flag);
        end
        step();
        ioctl_wr = 1'b0;
        checks++;
        if ({ioctl_wait, rom_wr} !== {1'b1, 4'b0}) begin
            errors++;
            $display("FAIL oob_hi: got wait=%b wr=%b exp 1 0000", ioctl_wait, rom_wr);
        end
        repeat (4) begin
            step();
            checks++;
            if ({ioctl_wait, rom_wr, err_flag} !== {1'b0, 4'b0, 1'b1}) begin
                errors++;
                $display("FAIL oob_ignored: got wait=%b wr=%b err=%b exp 0 0000 1",
                         ioctl_wait, rom_wr, err_flag);
            end
        end
        word(27'h0017FFF, 16'h9A8B);
    endtask

    task automatic test_random();
        int unsigned a;
        int unsigned gap;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                a = $urandom_range(0, 32'h180FF) & ~32'h1;
            end else begin
                a = RegEnd[$urandom_range(0, 3)] - 4 + $urandom_range(0, 7);
            end
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                step();
                checks++;
                if ({ioctl_wait, rom_wr} !== 5'b0) begin
                    errors++;
                    $display("FAIL rand_gap: got wait=%b wr=%b exp 0 0000", ioctl_wait, rom_wr);
                end
            end
            word(27'(a), 16'($urandom));
        end
    endtask

    task automatic test_reset_mid_word();
        ioctl_wr   = 1'b1;
        ioctl_addr = 27'h0000020;
        ioctl_dout = 16'h5A3C;
        step();
        ioctl_wr = 1'b0;
        checks++;
        if ({rom_wr, rom_data} !== {4'b0001, 8'h3C}) begin
            errors++;
            $display("FAIL mid_lo: got wr=%b data=%h exp 0001 3c", rom_wr, rom_data);
        end
        reset = 1'b1;
        step();
        reset   = 1'b0;
        err_exp = 1'b0;
        checks++;
        if ({ioctl_wait, rom_wr, err_flag} !== {1'b0, 4'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset: got wait=%b wr=%b err=%b exp 0 0000 0",
                     ioctl_wait, rom_wr, err_flag);
        end
        repeat (3) begin
            step();
            checks++;
            if ({ioctl_wait, rom_wr} !== 5'b0) begin
                errors++;
                $display("FAIL mid_no_hi: got wait=%b wr=%b exp 0 0000", ioctl_wait, rom_wr);
            end
        end
    endtask

    task automatic test_drop_mid_word();
        ioctl_wr   = 1'b1;
        ioctl_addr = 27'h0000040;
        ioctl_dout = 16'h1122;
        step();
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        checks++;
        if ({rom_wr, rom_addr, rom_data} !== {4'b0001, 16'h0040, 8'h22}) begin
            errors++;
            $display("FAIL drop_lo: got %b %h %h exp 0001 0040 22", rom_wr, rom_addr, rom_data);
        end
        step();
        checks++;
        if ({rom_wr, rom_addr, rom_data} !== {4'b0001, 16'h0041, 8'h11}) begin
            errors++;
            $display("FAIL drop_hi: got %b %h %h exp 0001 0041 11", rom_wr, rom_addr, rom_data);
        end
    endtask

    task automatic test_hold();
        ioctl_download = 1'b1;
        ioctl_index    = 8'd1;
        for (int i = 0; i < 6; i++) begin
            ioctl_wr   = i[0];
            ioctl_addr = 27'($urandom_range(0, 32'h17FFE));
            ioctl_dout = 16'($urandom);
            step();
            checks++;
            if ({rom_wr, ioctl_wait, core_reset, dl_done} !== {4'b0, 1'b0, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL idx1_ignored: got wr=%b wait=%b cr=%b done=%b exp 0000 0 1 0",
                         rom_wr, ioctl_wait, core_reset, dl_done);
            end
        end
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        count_hold("idx1", 1'b1);
        ioctl_download = 1'b1;
        repeat (3) step();
        ioctl_download = 1'b0;
        repeat (8) begin
            checks++;
            if ({core_reset, dl_done} !== 2'b10) begin
                errors++;
                $display("FAIL rehold_wait: got cr=%b done=%b exp 1 0", core_reset, dl_done);
            end
            step();
        end
        ioctl_download = 1'b1;
        repeat (2) begin
            step();
            checks++;
            if ({core_reset, dl_done} !== 2'b10) begin
                errors++;
                $display("FAIL rehold_reload: got cr=%b done=%b exp 1 0", core_reset, dl_done);
            end
        end
        ioctl_download = 1'b0;
        count_hold("rehold", 1'b1);
    endtask

    initial begin
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        test_reset();
        test_basic();
        test_regions();
        test_oob();
        test_random();
        test_reset_mid_word();
        ioctl_download = 1'b1;
        ioctl_index    = 8'd0;
        step();
        test_drop_mid_word();
        test_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
